// File: rtl/muldiv_unit.sv
// muldiv_unit: bit-serial RV32M/RV64M multiply/divide for the EX stage.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module muldiv_unit #(
   parameter int XLEN     = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StartE,
   input  logic [2:0]      Funct3E,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            FlushE,
   output logic            StallReq,
   output logic            Busy,
   output logic            Valid,
   output logic [XLEN-1:0] ResultE
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] f3_q, f3_d;
   logic negq_q, negq_d, negr_q, negr_d;
   logic [XLEN-1:0] m_q, m_d, res_q, res_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic is_div, sa_signed, sb_signed, s_a, s_b, div0, ovf, fast, accept;
   logic [XLEN-1:0] mag_a, mag_b, special_res, fast_res, mul_res, fin_res, quo, rem;
   logic [2*XLEN-1:0] ext_a, ext_b, prod, mul_step, div_step, step, step_fix;
   logic [XLEN:0] add, rem_sh, diff;

   assign is_div      = Funct3E[2];
   assign sa_signed   = is_div ? ~Funct3E[0] : (Funct3E[1:0] == 2'b01 || Funct3E[1:0] == 2'b10);
   assign sb_signed   = is_div ? ~Funct3E[0] : (Funct3E[1:0] == 2'b01);
   assign s_a         = sa_signed & SrcAE[XLEN-1];
   assign s_b         = sb_signed & SrcBE[XLEN-1];
   assign mag_a       = s_a ? -SrcAE : SrcAE;
   assign mag_b       = s_b ? -SrcBE : SrcBE;
   assign div0        = is_div & (SrcBE == '0);
   assign ovf         = is_div & ~Funct3E[0] & (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (SrcBE == '1);
   assign special_res = div0 ? (Funct3E[1] ? SrcAE : '1) : (Funct3E[1] ? '0 : SrcAE);
   assign fast        = FAST_MUL & ~is_div;
   assign ext_a       = {{XLEN{s_a}}, SrcAE};
   assign ext_b       = {{XLEN{s_b}}, SrcBE};
   assign prod        = FAST_MUL ? ext_a * ext_b : '0;
   assign fast_res    = (Funct3E[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   // multiply: add multiplicand into the high half, shift the pair right
   assign add      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
   assign mul_step = {add, acc_q[XLEN-1:1]};
   // divide: shift next dividend bit into the partial remainder, subtract if it fits
   assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
   assign diff     = rem_sh - {1'b0, m_q};
   assign div_step = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   assign step     = f3_q[2] ? div_step : mul_step;
   assign step_fix = negq_q ? -step : step;
   assign mul_res  = (f3_q[1:0] == 2'b00) ? step_fix[XLEN-1:0] : step_fix[2*XLEN-1:XLEN];
   assign quo      = step[XLEN-1:0];
   assign rem      = step[2*XLEN-1:XLEN];
   assign fin_res  = ~f3_q[2] ? mul_res : f3_q[1] ? (negr_q ? -rem : rem) : (negq_q ? -quo : quo);
   assign accept   = StartE & ~FlushE & (state_q != RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      m_d     = m_q;
      acc_d   = acc_q;
      res_d   = res_q;
      if (FlushE) begin
         state_d = IDLE;
      end else if (accept) begin
         f3_d    = Funct3E;
         negq_d  = s_a ^ s_b;
         negr_d  = s_a;
         cnt_d   = '0;
         m_d     = is_div ? mag_b : mag_a;
         acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
         state_d = (div0 | ovf | fast) ? DONE : RUN;
         res_d   = (div0 | ovf) ? special_res : fast ? fast_res : res_q;
      end else if (state_q == RUN) begin
         acc_d = step;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = DONE;
            res_d   = fin_res;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         m_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   assign Busy     = (state_q == RUN);
   assign Valid    = (state_q == DONE);
   assign StallReq = (StartE & ~FlushE & ~Busy) | Busy;
   assign ResultE  = res_q;
endmodule
